// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of post-decode stages,
// forwarding select, load-use stall, redirect flush and halt drain.
module pipe_hazard_ctrl #(
    parameter int DEPTH          = 3,
    parameter int REG_BITS       = 5,
    parameter int LOAD_READY     = 2,
    parameter int REDIRECT_STAGE = 1,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_halt,
    input  logic                redirect,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic [DEPTH-1:0]    flush_mask,
    output logic [DEPTH-1:0]    fwd_a,
    output logic [DEPTH-1:0]    fwd_b,
    output logic                stall,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
        logic                is_load;
    } sb_entry_t;

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;

    state_e state_q;
    state_e state_d;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;
    logic [DEPTH-1:0] sel_a;
    logic [DEPTH-1:0] sel_b;
    logic [DEPTH-1:0] load_early;
    logic [DEPTH-1:0] valid_vec;
    logic             haz_a;
    logic             haz_b;
    logic             redir_eff;
    logic             sb_empty;
    logic             issue;
    logic             in_run;

    // Keep only the youngest (lowest-index) producer of a register.
    function automatic logic [DEPTH-1:0] pick_lowest(
        input logic [DEPTH-1:0] v
    );
        logic [DEPTH-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (v[k] && !found) begin
                r[k]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign in_run = (state_q == RUN);

    // A halted core has no speculative work left, so redirect is dropped.
    assign redir_eff = redirect && (state_q != HALTED);

    // Per-entry source matches and loads whose data is not yet available.
    always_comb begin
        hit_a      = '0;
        hit_b      = '0;
        load_early = '0;
        valid_vec  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_vec[k] = sb_q[k].valid;
            hit_a[k] = id_uses_rs1 && sb_q[k].valid
                    && sb_q[k].regwrite
                    && (sb_q[k].rd == id_rs1)
                    && (id_rs1 != '0);
            hit_b[k] = id_uses_rs2 && sb_q[k].valid
                    && sb_q[k].regwrite
                    && (sb_q[k].rd == id_rs2)
                    && (id_rs2 != '0);
            load_early[k] = sb_q[k].is_load && (k < LOAD_READY);
        end
    end

    assign sel_a = pick_lowest(hit_a);
    assign sel_b = pick_lowest(hit_b);

    assign haz_a = |(sel_a & load_early);
    assign haz_b = |(sel_b & load_early);

    // A not-yet-ready load source reads nothing; the stall covers it.
    assign fwd_a = haz_a ? '0 : sel_a;
    assign fwd_b = haz_b ? '0 : sel_b;

    assign stall = id_valid && in_run && !redirect && (haz_a || haz_b);

    assign sb_empty = ~|valid_vec;

    assign issue = id_valid && !stall && !redirect && in_run && !id_halt;

    // Squash the stages younger than the resolving branch.
    always_comb begin
        flush_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            flush_mask[k] = redir_eff && (k < REDIRECT_STAGE);
        end
    end

    // Scoreboard shift: older stages always advance, decode fills entry 0.
    always_comb begin
        sb_d = '0;
        if (issue) begin
            sb_d[0].valid    = 1'b1;
            sb_d[0].rd       = id_rd;
            sb_d[0].regwrite = id_regwrite;
            sb_d[0].is_load  = id_memread;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
            if (redir_eff && (k <= REDIRECT_STAGE)) begin
                sb_d[k] = '0;
            end
        end
    end

    // Run/drain/halt sequencing; a redirect in drain cancels the halt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (id_valid && id_halt && !stall && !redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_d = RUN;
                end else if (sb_empty) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Front-end enables and flushes derived from state, stall, redirect.
    // In drain the PC enable stays low; the redirect target path
    // loads the PC on its own.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (stall) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (redirect) begin
                    if_id_flush = 1'b1;
                end
            end
            HALTED: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                pc_en    = 1'b1;
                if_id_en = 1'b1;
            end
        endcase
    end

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redir_eff && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // State registers with immediate clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q        <= '0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
